// File: rtl/lfsr_stats.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_stats
//  Description : Fibonacci LFSR that runs for exactly one full period from a
//                runtime seed, counting zero/one output bits and tracking the
//                longest run of each polarity along the way.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_stats #(
  parameter int               WIDTH = 13,
  parameter logic [WIDTH-1:0] TAPS  = 13'h1C80,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               RUN_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  output logic             lfsr_out,
  output logic             busy,
  output logic             done,
  output logic             seed_zero,
  output logic             max_tick,
  output logic [WIDTH-1:0] count_zero,
  output logic [WIDTH-1:0] count_one,
  output logic [RUN_W-1:0] max_run_zero,
  output logic [RUN_W-1:0] max_run_one
);

  // Period counter value seen on the edge that consumes the last bit of the
  // period (2^WIDTH-1 bits, counter starts at zero).
  localparam logic [WIDTH-1:0] c_last_idx  = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] c_one_w     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_zero_w    = '0;
  localparam logic [RUN_W-1:0] c_run_max   = {RUN_W{1'b1}};
  localparam logic [RUN_W-1:0] c_run_one   = {{(RUN_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           fsm_q,          fsm_d;
  logic [WIDTH-1:0] lfsr_q,         lfsr_d;
  logic [WIDTH-1:0] period_q,       period_d;
  logic [WIDTH-1:0] count_zero_q,   count_zero_d;
  logic [WIDTH-1:0] count_one_q,    count_one_d;
  logic [RUN_W-1:0] max_run_zero_q, max_run_zero_d;
  logic [RUN_W-1:0] max_run_one_q,  max_run_one_d;
  logic [RUN_W-1:0] cur_run_q,      cur_run_d;
  logic             prev_bit_q,     prev_bit_d;
  logic             seed_zero_q,    seed_zero_d;
  logic             max_tick_q,     max_tick_d;
  logic             busy_q,         busy_d;
  logic             done_q,         done_d;

  logic             w_fb;
  logic             w_bit;
  logic             w_first;
  logic [RUN_W-1:0] w_run_next;
  logic             w_seed_is_zero;

  // Feedback, consumed bit and the run length that the consumed bit produces.
  always_comb begin
    w_fb           = ^(lfsr_q & TAPS);
    w_bit          = lfsr_q[WIDTH-1];
    w_first        = (period_q == c_zero_w);
    w_seed_is_zero = (seed == c_zero_w);
    w_run_next     = c_run_one;
    if (!w_first && (w_bit == prev_bit_q)) begin
      // Saturate rather than wrap so a long run never looks short.
      w_run_next = (cur_run_q == c_run_max) ? cur_run_q : (cur_run_q + c_run_one);
    end
  end

  // Next-state logic for the FSM, LFSR and all statistics.
  always_comb begin
    fsm_d          = fsm_q;
    lfsr_d         = lfsr_q;
    period_d       = period_q;
    count_zero_d   = count_zero_q;
    count_one_d    = count_one_q;
    max_run_zero_d = max_run_zero_q;
    max_run_one_d  = max_run_one_q;
    cur_run_d      = cur_run_q;
    prev_bit_d     = prev_bit_q;
    seed_zero_d    = seed_zero_q;
    max_tick_d     = 1'b0;

    case (fsm_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          fsm_d          = ST_RUN;
          // An all-zero seed would lock the LFSR, so substitute 1.
          lfsr_d         = w_seed_is_zero ? c_one_w : seed;
          seed_zero_d    = w_seed_is_zero;
          period_d       = c_zero_w;
          count_zero_d   = c_zero_w;
          count_one_d    = c_zero_w;
          max_run_zero_d = '0;
          max_run_one_d  = '0;
          cur_run_d      = '0;
          prev_bit_d     = 1'b0;
        end
      end

      ST_RUN: begin
        if (abort) begin
          // Abort beats completion: nothing is consumed on this edge.
          fsm_d = ST_IDLE;
        end else begin
          if (w_bit) begin
            count_one_d = count_one_q + c_one_w;
            if (w_run_next > max_run_one_q) begin
              max_run_one_d = w_run_next;
            end
          end else begin
            count_zero_d = count_zero_q + c_one_w;
            if (w_run_next > max_run_zero_q) begin
              max_run_zero_d = w_run_next;
            end
          end
          cur_run_d  = w_run_next;
          prev_bit_d = w_bit;
          lfsr_d     = {lfsr_q[WIDTH-2:0], w_fb};
          period_d   = period_q + c_one_w;
          if (period_q == c_last_idx) begin
            fsm_d      = ST_DONE;
            max_tick_d = 1'b1;
          end
        end
      end

      default: begin
        fsm_d = ST_IDLE;
      end
    endcase

    // Status flags are registered copies of the next FSM state.
    busy_d = (fsm_d == ST_RUN);
    done_d = (fsm_d == ST_DONE);
  end

  // State registers with synchronous reset to the idle, seeded condition.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q          <= ST_IDLE;
      lfsr_q         <= SEED;
      period_q       <= '0;
      count_zero_q   <= '0;
      count_one_q    <= '0;
      max_run_zero_q <= '0;
      max_run_one_q  <= '0;
      cur_run_q      <= '0;
      prev_bit_q     <= 1'b0;
      seed_zero_q    <= 1'b0;
      max_tick_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      fsm_q          <= fsm_d;
      lfsr_q         <= lfsr_d;
      period_q       <= period_d;
      count_zero_q   <= count_zero_d;
      count_one_q    <= count_one_d;
      max_run_zero_q <= max_run_zero_d;
      max_run_one_q  <= max_run_one_d;
      cur_run_q      <= cur_run_d;
      prev_bit_q     <= prev_bit_d;
      seed_zero_q    <= seed_zero_d;
      max_tick_q     <= max_tick_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign lfsr_out     = lfsr_q[WIDTH-1];
  assign busy         = busy_q;
  assign done         = done_q;
  assign seed_zero    = seed_zero_q;
  assign max_tick     = max_tick_q;
  assign count_zero   = count_zero_q;
  assign count_one    = count_one_q;
  assign max_run_zero = max_run_zero_q;
  assign max_run_one  = max_run_one_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_stats.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_stats
//  Description : Directed bench for lfsr_stats: a WIDTH=4 instance for exact
//                bit-stream checks and a default WIDTH=13 instance for full
//                period statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_stats;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- WIDTH=4 instance ----------------
  logic       rst4, start4, abort4;
  logic [3:0] seed4;
  logic       out4, busy4, done4, sz4, tick4;
  logic [3:0] cz4, co4;
  logic [2:0] rz4, ro4;

  lfsr_stats #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b0001), .RUN_W(3)) u_dut4 (
    .clk(clk), .reset(rst4), .start(start4), .abort(abort4), .seed(seed4),
    .lfsr_out(out4), .busy(busy4), .done(done4), .seed_zero(sz4),
    .max_tick(tick4), .count_zero(cz4), .count_one(co4),
    .max_run_zero(rz4), .max_run_one(ro4)
  );

  // ---------------- default instance ----------------
  logic        rst13, start13, abort13;
  logic [12:0] seed13;
  logic        out13, busy13, done13, sz13, tick13;
  logic [12:0] cz13, co13;
  logic [3:0]  rz13, ro13;

  lfsr_stats u_dut13 (
    .clk(clk), .reset(rst13), .start(start13), .abort(abort13), .seed(seed13),
    .lfsr_out(out13), .busy(busy13), .done(done13), .seed_zero(sz13),
    .max_tick(tick13), .count_zero(cz13), .count_one(co13),
    .max_run_zero(rz13), .max_run_one(ro13)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walk the WIDTH=4 run until busy drops; ends in the cycle after it drops.
  task automatic run4(output int nbusy, output logic [14:0] stream, output int nticks);
    nbusy = 0; stream = '0; nticks = 0;
    for (int i = 0; i < 40 && busy4; i++) begin
      if (nbusy < 15) stream[14-nbusy] = out4;
      nbusy++;
      if (tick4) nticks++;
      step();
    end
    if (tick4) nticks++;
  endtask

  task automatic run13(output int nbusy, output int nticks);
    nbusy = 0; nticks = 0;
    for (int i = 0; i < 9000 && busy13; i++) begin
      nbusy++;
      if (tick13) nticks++;
      step();
    end
    if (tick13) nticks++;
  endtask

  task automatic pulse4(input logic [3:0] s);
    seed4 = s; start4 = 1'b1; step(); start4 = 1'b0;
  endtask

  task automatic pulse13(input logic [12:0] s);
    seed13 = s; start13 = 1'b1; step(); start13 = 1'b0;
  endtask

  initial begin
    int nb, nt;
    logic [14:0] st;

    rst4 = 1'b1; start4 = 1'b0; abort4 = 1'b0; seed4 = '0;
    rst13 = 1'b1; start13 = 1'b0; abort13 = 1'b0; seed13 = '0;
    step(); step();

    // Reset values
    chk("rst4_out", out4, 0);
    chk("rst4_busy", busy4, 0);
    chk("rst4_done", done4, 0);
    chk("rst4_tick", tick4, 0);
    chk("rst4_sz", sz4, 0);
    chk("rst4_counts", {cz4, co4, 1'b0, rz4, 1'b0, ro4}, 0);
    chk("rst13_busy_done_tick", {busy13, done13, tick13, sz13}, 0);
    chk("rst13_counts", {cz13, co13}, 0);
    rst4 = 1'b0; rst13 = 1'b0;
    step();

    // WIDTH=4 full period from seed 0001
    pulse4(4'b0001);
    chk("w4_busy_after_start", busy4, 1);
    run4(nb, st, nt);
    chk("w4_busy_cycles", nb, 15);
    chk("w4_stream", st, 15'b000100110101111);
    chk("w4_done", done4, 1);
    chk("w4_count_one", co4, 8);
    chk("w4_count_zero", cz4, 7);
    chk("w4_max_run_one", ro4, 4);
    chk("w4_max_run_zero", rz4, 3);
    chk("w4_final_msb", out4, 0);
    step();
    if (tick4) nt++;
    chk("w4_tick_count", nt, 1);
    chk("w4_done_hold", done4, 1);

    // Abort after 5 consumed bits
    pulse4(4'b0001);
    repeat (5) step();
    abort4 = 1'b1; step(); abort4 = 1'b0;
    chk("ab_busy", busy4, 0);
    chk("ab_done", done4, 0);
    chk("ab_tick", tick4, 0);
    chk("ab_count_zero", cz4, 4);
    chk("ab_count_one", co4, 1);
    step(); step();
    chk("ab_hold", {tick4, cz4, co4}, {1'b0, 4'd4, 4'd1});
    chk("ab_lfsr_held", out4, 0);

    // Restart clears and completes
    pulse4(4'b0001);
    chk("rs_cleared", {cz4, co4}, 0);
    run4(nb, st, nt);
    chk("rs_busy_cycles", nb, 15);
    chk("rs_counts", {cz4, co4}, {4'd7, 4'd8});

    // Seed zero behaves as seed one
    pulse4(4'b0000);
    chk("sz_flag", sz4, 1);
    run4(nb, st, nt);
    chk("sz_stream", st, 15'b000100110101111);
    chk("sz_stats", {cz4, co4, rz4, ro4}, {4'd7, 4'd8, 3'd3, 3'd4});

    // Abort together with start on the final consumption edge
    pulse4(4'b0001);
    chk("sz_cleared_on_nonzero", sz4, 0);
    repeat (14) step();
    chk("fa_last_busy", busy4, 1);
    abort4 = 1'b1; start4 = 1'b1; step(); abort4 = 1'b0; start4 = 1'b0;
    chk("fa_state", {busy4, done4, tick4}, 3'b000);
    chk("fa_counts", {cz4, co4}, {4'd7, 4'd7});
    chk("fa_runs", {rz4, ro4}, {3'd3, 3'd3});
    step();
    chk("fa_no_tick", tick4, 0);

    // Start held high across DONE: one start per visit, back-to-back runs
    seed4 = 4'b0001; start4 = 1'b1; step();
    run4(nb, st, nt);
    chk("hs_first_counts", {done4, cz4, co4}, {1'b1, 4'd7, 4'd8});
    step();
    chk("hs_restart_busy", busy4, 1);
    chk("hs_restart_clear", {cz4, co4}, 0);
    run4(nb, st, nt);
    chk("hs_second_busy", nb, 15);
    chk("hs_second_tick", nt, 1);
    start4 = 1'b0; step();
    chk("hs_done_hold", {busy4, done4, tick4, co4}, {3'b010, 4'd8});

    // Default instance, seed 1
    pulse13(13'd1);
    run13(nb, nt);
    chk("d_busy_cycles", nb, 8191);
    chk("d_count_one", co13, 4096);
    chk("d_count_zero", cz13, 4095);
    chk("d_max_run_one", ro13, 13);
    chk("d_max_run_zero", rz13, 12);
    chk("d_done", done13, 1);
    step();
    if (tick13) nt++;
    chk("d_tick_single", nt, 1);

    // Default instance, seed 0
    pulse13(13'd0);
    chk("d0_sz", sz13, 1);
    run13(nb, nt);
    chk("d0_busy_cycles", nb, 8191);
    chk("d0_stats", {cz13, co13, rz13, ro13}, {13'd4095, 13'd4096, 4'd12, 4'd13});

    // Reset during a run
    pulse13(13'd0);
    repeat (99) step();
    rst13 = 1'b1; step(); rst13 = 1'b0;
    chk("mr_flags", {busy13, done13, tick13, sz13}, 4'b0000);
    chk("mr_counts", {cz13, co13, rz13, ro13}, 0);
    chk("mr_out", out13, 0);
    step();
    chk("mr_idle", {busy13, tick13}, 2'b00);
    pulse13(13'd1);
    run13(nb, nt);
    chk("mr_rerun", {cz13, co13}, {13'd4095, 13'd4096});
    chk("mr_rerun_tick", nt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lfsr_stats.md
# lfsr_stats

Parametrised Fibonacci LFSR with on-line bit statistics, the successor to the fixed 13-bit LFSR zero/one counter in the lab designs. A start/abort handshake runs the LFSR for exactly one full period (2^WIDTH-1 shifts) from a runtime seed. Over that period the block counts output zeros and ones and tracks the longest run of each polarity. It sits beside the lab test harness as a self-checking randomness source and statistic engine.

## Interface
- WIDTH, 13: LFSR length in bits, 3..16.
- TAPS, 13'h1C80: feedback mask, WIDTH bits; bit i set means state[i] feeds the XOR. The default is x^13+x^12+x^11+x^8+1, which must be maximal-length.
- SEED, 1: reset value of the LFSR state; must be non-zero.
- RUN_W, $clog2(WIDTH+1): width of the run-length outputs.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a period. Sampled only in IDLE or DONE.
- abort  in  1  terminate a period. Sampled only in RUN.
- seed  in  WIDTH  seed captured on an accepted start.
- lfsr_out  out  1  current output bit, equal to state[WIDTH-1].
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- seed_zero  out  1  high if the last accepted seed was all-zero.
- max_tick  out  1  one-cycle pulse when a full period completes.
- count_zero  out  WIDTH  number of zero bits consumed.
- count_one  out  WIDTH  number of one bits consumed.
- max_run_zero  out  RUN_W  longest run of consecutive zeros.
- max_run_one  out  RUN_W  longest run of consecutive ones.

## Operation
- Shift rule: fb = ^(state & TAPS); state <= {state[WIDTH-2:0], fb}. The consumed bit is state[WIDTH-1] before the shift.
- The FSM has three states: IDLE, RUN and DONE.
- IDLE -> RUN when start=1. On the same edge:
  - state <= seed, or 1 if seed==0; seed_zero <= (seed==0).
  - count_zero, count_one, both max_run registers, cur_run, prev_bit and the period counter are all cleared.
- In RUN, each edge:
  - Consume one bit and increment count_zero or count_one.
  - Run length: if the bit equals prev_bit and this is not the first bit, cur_run+1; otherwise cur_run=1.
  - Update max_run_<polarity> if cur_run(new) exceeds it.
  - Shift the LFSR and increment the period counter.
  - Run counters saturate at 2^RUN_W-1.
- RUN -> DONE on the edge that consumes the (2^WIDTH-1)th bit. max_tick is high for the following cycle only. At that point the state equals the loaded seed again.
- RUN -> IDLE on abort=1. Partial statistics are held, max_tick is not asserted, and the LFSR holds its state.
- DONE -> RUN on start=1, using the same load actions as IDLE -> RUN. Otherwise DONE holds all outputs.
- In IDLE and DONE the LFSR does not shift.

## Timing
- Reset values:
  - state = SEED, so lfsr_out = SEED[WIDTH-1].
  - FSM = IDLE.
  - busy, done, max_tick and seed_zero = 0.
  - All counts and runs = 0.
- All outputs are registered or decoded directly from registers; there is no combinational input-to-output path.
- Start latency: busy rises in the cycle after the start edge, and the first bit is consumed on the next edge.
- A full period is 2^WIDTH-1 cycles with busy high. done and max_tick rise together one cycle after the final consumption edge. Statistics are final in that cycle.
- Simultaneous start and abort:
  - In IDLE/DONE, start wins.
  - In RUN, abort wins and start is ignored, including on the final consumption edge. In that case the FSM goes to IDLE with no max_tick and the final bit is not counted.
- Reset mid-RUN: the next cycle shows full reset values; no max_tick.
- count_zero + count_one always equals the number of consumed bits.

## Test plan
- WIDTH=4, TAPS=4'b1100, seed=4'b0001, start pulse:
  - Bit stream 000100110101111.
  - 15 busy cycles, max_tick pulsed once.
  - count_one=8, count_zero=7, max_run_one=4, max_run_zero=3, final state 0001.
- Defaults, seed=1: after 8191 busy cycles, count_one=4096, count_zero=4095, max_run_one=13, max_run_zero=12. done=1 and max_tick is a single cycle.
- Seed 0: seed_zero=1, behaviour identical to seed=1, and statistics match the previous case.
- WIDTH=4 case, abort after 5 consumed bits: FSM returns to IDLE, count_zero=4, count_one=1, and no max_tick. A restart then clears the counts and completes with 8/7.
- Reset asserted at cycle 100 of a default run: all outputs return to reset values next cycle. A new start then completes normally with 4096/4095.
- Restart from DONE with start held high for multiple cycles: only one start is accepted per IDLE/DONE visit. start is ignored during RUN, so runs are back-to-back with statistics cleared each time.
